// File: rtl/rx_west_axis.sv
// Darwin3 west-port receiver: 4-phase REQ/ACK words into a FIFO, out as an AXI4-Stream master with TLAST by beat count.
// Latency: REQ edge to ACK edge is SYNC_STAGES+1 cycles; a written word is visible on TVALID/TDATA the cycle after the write.
// Backpressure: TREADY low fills the FIFO; when it is full the FSM holds ACK low, stalling the chip's REQ.

// Generic single-clock FIFO with first-word fall-through read side.
// Latency: a push is visible on rd_vld/rd_dat the following cycle.
// Backpressure: full is derived from the registered count; pushes while full are ignored.
module fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign rd_vld = (cnt != '0);
    // Gate the head word so the output reads zero while empty (including out of reset).
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
    assign push   = wr_vld && !full;
    assign pop    = rd_rdy && rd_vld;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset because rd_dat is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module rx_west_axis #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PKT_LEN     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   RX_DATA_WEST,
    input  logic                RX_REQ_WEST,
    output logic                RX_ACK_WEST,
    output logic [DATA_W-1:0]   M_AXIS_TDATA,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
    output logic                M_AXIS_TLAST
);
    typedef enum logic [1:0] {RESYNC, IDLE, WAIT_LOW} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   ack_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   req_s;
    logic                   fill_done;
    logic                   wr_vld;
    logic                   fifo_full;

    assign req_s       = sync_q[SYNC_STAGES-1];
    // The synchronizer is cleared by reset, so its output only reflects the real
    // REQ once it has refilled; RESYNC waits for that before trusting req_s==0.
    assign fill_done   = fill_q[SYNC_STAGES-1];
    assign RX_ACK_WEST = ack_q;
    assign M_AXIS_TKEEP = '1;

    // REQ synchronizer plus a marker of how many stages hold post-reset samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_REQ_WEST};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Handshake state register; ACK is registered and high exactly in WAIT_LOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESYNC;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == WAIT_LOW);
        end
    end

    // Next-state logic; the single FIFO write of a REQ phase happens on leaving IDLE.
    always_comb begin
        state_d = state_q;
        wr_vld  = 1'b0;
        case (state_q)
            RESYNC: begin
                if (fill_done && !req_s) state_d = IDLE;
            end
            IDLE: begin
                if (req_s && !fifo_full) begin
                    wr_vld  = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!req_s) state_d = IDLE;
            end
            default: state_d = RESYNC;
        endcase
    end

    fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (wr_vld),
        .wr_dat (RX_DATA_WEST),
        .rd_rdy (M_AXIS_TREADY),
        .rd_vld (M_AXIS_TVALID),
        .rd_dat (M_AXIS_TDATA),
        .full   (fifo_full)
    );

    generate
        if (PKT_LEN > 0) begin : g_last
            localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
            logic [CW-1:0] beat_q;
            logic          at_last;
            logic          beat;

            assign beat         = M_AXIS_TVALID && M_AXIS_TREADY;
            assign at_last      = (beat_q == CW'(PKT_LEN - 1));
            assign M_AXIS_TLAST = M_AXIS_TVALID && at_last;

            // Beat counter: advances per accepted beat, wraps after the last beat of a packet.
            always_ff @(posedge clk) begin
                if (rst) begin
                    beat_q <= '0;
                end else if (beat) begin
                    beat_q <= at_last ? '0 : beat_q + CW'(1);
                end
            end
        end else begin : g_nolast
            assign M_AXIS_TLAST = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_rx_west_axis.sv
// Bench for rx_west_axis: chip-side REQ/ACK model drives words, expected beats queue in a scoreboard.
// A default-parameter instance covers handshake, framing, backpressure and reset; a PKT_LEN=0 instance covers TLAST disable.
// A negedge monitor pops and compares on every TVALID&TREADY and checks hold stability during stalls.
module tb_rx_west_axis;
    logic        clk;
    logic        rst;

    logic [15:0] dat_a, dat_b;
    logic        req_a, req_b;
    logic        ack_a, ack_b;
    logic [15:0] tdata_a, tdata_b;
    logic        tvalid_a, tvalid_b;
    logic        tready_a, tready_b;
    logic [1:0]  tkeep_a, tkeep_b;
    logic        tlast_a, tlast_b;

    int          errors = 0;
    int          checks = 0;
    logic [16:0] sb_a[$];
    logic [16:0] sb_b[$];
    int          sent_a = 0;
    int          rdy_mode = 1;   // 0: TREADY low, 1: high, 2: random
    int          ack_rises = 0;

    rx_west_axis #(.DATA_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2), .PKT_LEN(16)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .RX_DATA_WEST  (dat_a),
        .RX_REQ_WEST   (req_a),
        .RX_ACK_WEST   (ack_a),
        .M_AXIS_TDATA  (tdata_a),
        .M_AXIS_TVALID (tvalid_a),
        .M_AXIS_TREADY (tready_a),
        .M_AXIS_TKEEP  (tkeep_a),
        .M_AXIS_TLAST  (tlast_a)
    );

    rx_west_axis #(.DATA_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2), .PKT_LEN(0)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .RX_DATA_WEST  (dat_b),
        .RX_REQ_WEST   (req_b),
        .RX_ACK_WEST   (ack_b),
        .M_AXIS_TDATA  (tdata_b),
        .M_AXIS_TVALID (tvalid_b),
        .M_AXIS_TREADY (tready_b),
        .M_AXIS_TKEEP  (tkeep_b),
        .M_AXIS_TLAST  (tlast_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Sole driver of tready_a; applied shortly after each rising edge.
    initial begin
        tready_a = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       tready_a = 1'b0;
                1:       tready_a = 1'b1;
                default: tready_a = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard compare on accepted beats, stall stability, ACK rise count.
    initial begin
        logic        stall_q;
        logic [16:0] stall_v;
        logic        ack_prev;
        stall_q  = 1'b0;
        stall_v  = '0;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q  = 1'b0;
                ack_prev = 1'b0;
            end else begin
                if (ack_a && !ack_prev) ack_rises++;
                ack_prev = ack_a;
                if (stall_q) begin
                    check("stall_valid_a", 32'(tvalid_a), 32'd1);
                    check("stall_hold_a", 32'({tlast_a, tdata_a}), 32'(stall_v));
                end
                stall_q = tvalid_a && !tready_a;
                stall_v = {tlast_a, tdata_a};
                if (tvalid_a && tready_a) begin
                    if (sb_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_a: unexpected beat %h, want none", tdata_a);
                    end else begin
                        check("beat_a", 32'({tlast_a, tdata_a}), 32'(sb_a.pop_front()));
                        check("keep_a", 32'(tkeep_a), 32'h3);
                    end
                end
                if (tvalid_b && tready_b) begin
                    if (sb_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_b: unexpected beat %h, want none", tdata_b);
                    end else begin
                        check("beat_b", 32'({tlast_b, tdata_b}), 32'(sb_b.pop_front()));
                        check("keep_b", 32'(tkeep_b), 32'h3);
                    end
                end
            end
        end
    end

    task automatic wait_ack(input bit sel, input logic lvl, output int c);
        c = 0;
        while (((sel ? ack_b : ack_a) !== lvl) && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        if ((sel ? ack_b : ack_a) !== lvl) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: ack stayed %b, want %b", sel ? ack_b : ack_a, lvl);
        end
    endtask

    // One complete 4-phase transfer; the expected beat is queued before REQ rises.
    task automatic send(input bit sel, input logic [15:0] d);
        int c;
        if (!sel) begin
            dat_a = d;
            sb_a.push_back({(sent_a % 16 == 15), d});
            sent_a++;
            req_a = 1'b1;
        end else begin
            dat_b = d;
            sb_b.push_back({1'b0, d});
            req_b = 1'b1;
        end
        wait_ack(sel, 1'b1, c);
        if (!sel) req_a = 1'b0;
        else      req_b = 1'b0;
        wait_ack(sel, 1'b0, c);
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while ((sel ? (tvalid_b || sb_b.size() > 0) : (tvalid_a || sb_a.size() > 0)) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(sel ? "drain_b" : "drain_a", sel ? sb_b.size() : sb_a.size(), 0);
    endtask

    task automatic do_reset();
        drain(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_a.delete();
        sent_a = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c;
        int base;
        rst      = 1'b1;
        req_a    = 1'b0;
        req_b    = 1'b0;
        dat_a    = '0;
        dat_b    = '0;
        tready_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_tvalid", 32'(tvalid_a), 32'd0);
        check("rst_tlast", 32'(tlast_a), 32'd0);
        check("rst_tdata", 32'(tdata_a), 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // Single word with handshake latency
        dat_a = 16'h1111;
        sb_a.push_back({1'b0, 16'h1111});
        sent_a++;
        req_a = 1'b1;
        wait_ack(1'b0, 1'b1, c);
        check("t1_req_rise_to_ack", c, 3);
        req_a = 1'b0;
        wait_ack(1'b0, 1'b0, c);
        check("t1_req_fall_to_ack", c, 3);

        // 17-word stream: TLAST on beat 16 (16'h1110), counter restarts on beat 17
        do_reset();
        for (int k = 1; k <= 17; k++) send(1'b0, 16'(16'h1111 * k));
        drain(1'b0);

        // Backpressure: 8 words fill the FIFO, the 9th REQ waits
        do_reset();
        rdy_mode = 0;
        base = ack_rises;
        for (int k = 1; k <= 8; k++) send(1'b0, 16'(16'h3000 + k));
        dat_a = 16'h3009;
        sb_a.push_back({1'b0, 16'h3009});
        sent_a++;
        req_a = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("t3_acks_while_full", ack_rises - base, 8);
        check("t3_ack_held_low", 32'(ack_a), 32'd0);
        check("t3_tvalid_held", 32'(tvalid_a), 32'd1);
        check("t3_tdata_head", 32'(tdata_a), 32'h3001);
        rdy_mode = 1;
        wait_ack(1'b0, 1'b1, c);
        req_a = 1'b0;
        wait_ack(1'b0, 1'b0, c);
        send(1'b0, 16'h300A);
        drain(1'b0);
        check("t3_acks_total", ack_rises - base, 10);

        // Random TREADY, 64 words, TLAST every 16th
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 64; i++) send(1'b0, 16'(16'hA000 ^ (i * 16'h0137)));
        drain(1'b0);
        rdy_mode = 1;

        // Reset with REQ and ACK high and three words buffered
        do_reset();
        rdy_mode = 0;
        send(1'b0, 16'h5001);
        send(1'b0, 16'h5002);
        dat_a = 16'h5003;
        req_a = 1'b1;
        wait_ack(1'b0, 1'b1, c);
        check("t5_buffered_before_rst", 32'(tvalid_a), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_a.delete();
        sent_a = 0;
        check("t5_ack_after_rst", 32'(ack_a), 32'd0);
        check("t5_tvalid_after_rst", 32'(tvalid_a), 32'd0);
        base = ack_rises;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("t5_no_recapture_ack", 32'(ack_a), 32'd0);
        check("t5_no_recapture_tvalid", 32'(tvalid_a), 32'd0);
        req_a = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        send(1'b0, 16'h5555);
        drain(1'b0);
        check("t5_single_capture", ack_rises - base, 1);

        // PKT_LEN=0 instance: 40 beats, TLAST never set
        for (int i = 0; i < 40; i++) send(1'b1, 16'(16'h6000 + i));
        drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
